trng_word_assembler: RTL and testbench
======================================

// Module: trng_word_assembler
// PURPOSE
//  Parametrised successor to top_trng's sampling/packing path. Samples NUM_CH asynchronous
//  ring-oscillator outputs and XOR-combines them into one raw bit per sample. Optionally
//  applies von Neumann debiasing and runs a repetition-count health test. Packs accepted bits
//  into OUT_W-bit words, buffered in a small FIFO with a valid/ready output. Sits between the
//  RO bank and the AXI/PS-facing register logic.
// PARAMETERS
//  NUM_CH      4   number of RO inputs XOR-combined per sample (>=1)
//  OUT_W       64  output word width (>=2)
//  DECIM       8   clocks between sample strobes (>=1)
//  RCT_CUTOFF  32  consecutive identical raw samples that trip health_fail (>=2)
//  FIFO_DEPTH  4   output word FIFO depth (power of 2, >=2)
// PORTS
//  clk          in   1           system clock (50 MHz nominal)
//  rst          in   1           asynchronous, active-low reset
//  enable       in   1           collect entropy while high
//  mode_vn      in   1           1 = von Neumann debias, 0 = raw bits; sampled only at enable rise
//  ro_raw       in   NUM_CH      asynchronous RO outputs
//  data_out     out  OUT_W       FIFO head word
//  data_valid   out  1           FIFO not empty
//  data_ready   in   1           consumer accepts head word when data_valid & data_ready
//  health_fail  out  1           sticky repetition-count failure
// BEHAVIOUR
//  - Reset (rst=0): all state cleared. data_out=0, data_valid=0, health_fail=0, FIFO empty.
//  - Synchroniser: 2-flop synchroniser per channel, always running; raw = XOR of synced bits.
//  - Strobe: decimation counter counts 0..DECIM-1 while enable=1; strobe when count==DECIM-1.
//    One raw sample is taken per strobe.
//  - RCT: counts consecutive equal raw samples, counter starting at 1. On reaching RCT_CUTOFF,
//    health_fail=1 (sticky). While health_fail=1: no bits are accepted, the partial word is
//    discarded, and no pushes occur.
//  - mode_vn=0: every strobe sample is an accepted bit.
//  - mode_vn=1: samples are paired (first, second). 01 -> accept 0; 10 -> accept 1;
//    00/11 -> discard both.
//  - Packing: shreg <= {shreg[OUT_W-2:0], bit}, so the first bit lands in the MSB. The bit
//    counter wraps at OUT_W. On the OUT_W-th bit, the full word is pushed to the FIFO in the
//    same edge and the counter resets to 0.
//  - Stall: while the FIFO is full and no pop occurs this cycle, strobes are ignored. The
//    decimation counter holds and no samples are taken, so no bits are lost or reordered.
//  - FIFO: push accepted if !full || pop. Simultaneous push and pop on a full FIFO is legal;
//    the count is unchanged. data_valid rises the cycle after the push edge. data_out is
//    stable while data_valid=1 and data_ready=0.
//  - enable 1->0: clears the decimation counter, shreg, bit counter, VN pair state, RCT
//    counter and health_fail. FIFO contents are retained and drainable. Latches mode_vn at the
//    next rise.
//  - Reset mid-word: the partial word is lost; the first word after reset contains only
//    post-reset bits.
// STRUCTURE
//  - Shared include trng_defs.vh holds the default OUT_W, DECIM, RCT_CUTOFF and FIFO_DEPTH,
//    plus the VN pair-state encoding (VN_IDLE, VN_HAVE_FIRST), for reuse by top_trng and the
//    register block.
//  - One sub-module: trng_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count). Uses the same
//    clk and active-low async rst.
//  - Sample, VN, RCT and packing logic stay in this module.
// TESTING (DECIM=1, OUT_W=8, FIFO_DEPTH=4, RCT_CUTOFF=8 unless stated)
//  1. NUM_CH=1, mode_vn=0, ro_raw bits 1,0,1,1,0,0,1,0 over 8 strobes (after 2-cycle sync)
//     -> data_out=8'hB2, data_valid rises 1 cycle after the 8th accepted bit.
//  2. NUM_CH=4: ch0 only high -> raw=1; ch0 and ch1 high -> raw=0. Verify packing gives
//     8'hFF and 8'h00 respectively, with RCT_CUTOFF=32 so the health test does not trip.
//  3. mode_vn=1, pairs 01,10,11,00,10,10,01,01,10,01 -> accepted bits 0,1,1,1,0,0,1,0,
//     giving 8'h72.
//  4. data_ready=0: 4 words fill the FIFO, then no further pushes and shreg holds. Then
//     data_ready=1 -> words pop in push order, collection resumes, and no bit gap occurs
//     versus the driven sequence.
//  5. ro_raw held at 1 -> health_fail=1 on the 8th identical sample, no word pushed.
//     enable 0 then 1 -> health_fail=0, normal output resumes.
//  6. rst low after 5 accepted bits -> all outputs 0 asynchronously. After release, the first
//     word equals the next 8 driven bits only. Also check push+pop on a full FIFO keeps
//     count=4.

Source files
------------

// File: rtl/trng_word_assembler_pkg.sv
// Shared defaults, von Neumann pair-state encoding and width helper for the TRNG sampling path.
package trng_word_assembler_pkg;

  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_OUT_W      = 64;
  localparam int unsigned DEF_DECIM      = 8;
  localparam int unsigned DEF_RCT_CUTOFF = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    VN_IDLE       = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock word FIFO; push is accepted when not full or when a pop happens in the same cycle.
module trng_sync_fifo
  import trng_word_assembler_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_push_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_head_c,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_pop_ok  = i_pop && !r_empty;
  assign w_push_ok = i_push && (!r_full || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Flags are registered from the next count so they track r_count exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_full   = r_full;
  assign o_empty  = r_empty;
  assign o_count  = r_count;

endmodule

// File: rtl/trng_word_assembler.sv
// Samples and XOR-combines RO outputs, optionally von Neumann debiases, runs a repetition-count
// health test and packs accepted bits MSB-first into words queued in a small FIFO.
module trng_word_assembler
  import trng_word_assembler_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned DECIM      = DEF_DECIM,
  parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode_vn,
  input  logic [NUM_CH-1:0] ro_raw,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              health_fail
);

  localparam int unsigned DEC_W = cnt_w(DECIM - 1);
  localparam int unsigned BIT_W = cnt_w(OUT_W - 1);
  localparam int unsigned RCT_W = cnt_w(RCT_CUTOFF);
  localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH);

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic              r_en_d;
  logic              r_mode_vn;
  logic [DEC_W-1:0]  r_dcnt;
  logic              r_last_raw;
  logic [RCT_W-1:0]  r_rct_cnt;
  logic              r_health_fail;
  vn_state_e         r_vn_state;
  logic              r_vn_first;
  logic [OUT_W-1:0]  r_shreg;
  logic [BIT_W-1:0]  r_bcnt;

  logic              w_raw;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_unused_fifo_count;
  logic              w_pop;
  logic              w_stall;
  logic              w_en_rise;
  logic              w_mode_vn;
  logic              w_strobe;
  logic              w_sample;
  logic              w_rct_same;
  logic              w_trip;
  logic              w_bit_vld;
  logic              w_bit;
  logic              w_push;
  logic [OUT_W-1:0]  w_push_data;

  assign w_raw      = ^r_sync2;
  assign data_valid = !w_empty;
  assign w_pop      = data_valid && data_ready;
  // A full FIFO with no pop freezes sampling so no accepted bit is ever dropped.
  assign w_stall    = w_full && !w_pop;
  assign w_en_rise  = enable && !r_en_d;
  assign w_mode_vn  = w_en_rise ? mode_vn : r_mode_vn;
  assign w_strobe   = enable && !w_stall && (r_dcnt == DEC_W'(DECIM - 1));
  assign w_sample   = w_strobe && !r_health_fail;
  assign w_rct_same = (r_rct_cnt != '0) && (w_raw == r_last_raw);
  assign w_trip     = w_sample && w_rct_same && (r_rct_cnt == RCT_W'(RCT_CUTOFF - 1));

  // Bit acceptance: raw mode takes every sample, debias mode emits the first of an unequal pair.
  always_comb begin
    w_bit_vld = 1'b0;
    w_bit     = w_raw;
    if (w_sample && !w_trip) begin
      if (!w_mode_vn) begin
        w_bit_vld = 1'b1;
      end else if ((r_vn_state == VN_HAVE_FIRST) && (r_vn_first != w_raw)) begin
        w_bit_vld = 1'b1;
        w_bit     = r_vn_first;
      end
    end
  end

  assign w_push      = w_bit_vld && (r_bcnt == BIT_W'(OUT_W - 1));
  assign w_push_data = {r_shreg[OUT_W-2:0], w_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_en_d        <= 1'b0;
      r_mode_vn     <= 1'b0;
      r_dcnt        <= '0;
      r_last_raw    <= 1'b0;
      r_rct_cnt     <= '0;
      r_health_fail <= 1'b0;
      r_vn_state    <= VN_IDLE;
      r_vn_first    <= 1'b0;
      r_shreg       <= '0;
      r_bcnt        <= '0;
    end else begin
      r_sync1 <= ro_raw;
      r_sync2 <= r_sync1;
      r_en_d  <= enable;
      if (w_en_rise) begin
        r_mode_vn <= mode_vn;
      end
      if (!enable) begin
        r_dcnt        <= '0;
        r_last_raw    <= 1'b0;
        r_rct_cnt     <= '0;
        r_health_fail <= 1'b0;
        r_vn_state    <= VN_IDLE;
        r_vn_first    <= 1'b0;
        r_shreg       <= '0;
        r_bcnt        <= '0;
      end else begin
        if (!w_stall) begin
          r_dcnt <= (r_dcnt == DEC_W'(DECIM - 1)) ? '0 : r_dcnt + DEC_W'(1);
        end
        if (w_sample) begin
          r_last_raw <= w_raw;
          r_rct_cnt  <= w_rct_same ? r_rct_cnt + RCT_W'(1) : RCT_W'(1);
        end
        if (w_trip) begin
          r_health_fail <= 1'b1;
          r_vn_state    <= VN_IDLE;
          r_shreg       <= '0;
          r_bcnt        <= '0;
        end else begin
          if (w_sample && w_mode_vn) begin
            if (r_vn_state == VN_IDLE) begin
              r_vn_state <= VN_HAVE_FIRST;
              r_vn_first <= w_raw;
            end else begin
              r_vn_state <= VN_IDLE;
            end
          end
          if (w_bit_vld) begin
            r_shreg <= w_push_data;
            r_bcnt  <= w_push ? '0 : r_bcnt + BIT_W'(1);
          end
        end
      end
    end
  end

  assign health_fail = r_health_fail;

  trng_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head_c    (data_out),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_unused_fifo_count)
  );

endmodule

// File: tb/tb_trng_word_assembler.sv
// Directed bench: single-channel and four-channel assemblers plus a standalone word FIFO.
module tb_trng_word_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_en = 1'b0, a_mode = 1'b0, a_rdy = 1'b0;
  logic [0:0] a_ro = '0;
  logic [7:0] a_out;
  logic       a_vld, a_hf;

  logic       b_en = 1'b0, b_mode = 1'b0, b_rdy = 1'b0;
  logic [3:0] b_ro = '0;
  logic [7:0] b_out;
  logic       b_vld, b_hf;

  logic       f_push = 1'b0, f_pop = 1'b0;
  logic [7:0] f_din = '0;
  logic [7:0] f_head;
  logic       f_full, f_empty;
  logic [2:0] f_cnt;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  typedef struct {
    logic        mode;
    int          n;
    logic [31:0] bits;
    int          nw;
    logic [7:0]  w0;
    logic [7:0]  w1;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  trng_word_assembler #(
    .NUM_CH(1), .OUT_W(8), .DECIM(1), .RCT_CUTOFF(8), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst_n), .enable(a_en), .mode_vn(a_mode), .ro_raw(a_ro),
    .data_out(a_out), .data_valid(a_vld), .data_ready(a_rdy), .health_fail(a_hf)
  );

  trng_word_assembler #(
    .NUM_CH(4), .OUT_W(8), .DECIM(1), .RCT_CUTOFF(32), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst_n), .enable(b_en), .mode_vn(b_mode), .ro_raw(b_ro),
    .data_out(b_out), .data_valid(b_vld), .data_ready(b_rdy), .health_fail(b_hf)
  );

  trng_sync_fifo #(.WIDTH(8), .DEPTH(4)) u_fchk (
    .clk(clk), .rst_n(rst_n), .i_push(f_push), .i_push_data(f_din), .i_pop(f_pop),
    .o_head_c(f_head), .o_full(f_full), .o_empty(f_empty), .o_count(f_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Score any word handed over this cycle, then advance to 1 time unit past the next edge.
  task automatic step();
    if (a_vld && a_rdy) begin
      if (qa.size() == 0) check("a_unexpected_word", 32'(a_out), 32'hFFFF_FFFF);
      else check("a_word", 32'(a_out), 32'(qa.pop_front()));
    end
    if (b_vld && b_rdy) begin
      if (qb.size() == 0) check("b_unexpected_word", 32'(b_out), 32'hFFFF_FFFF);
      else check("b_word", 32'(b_out), 32'(qb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  // Bit j driven at step j is sampled three edges later; enable rises at step 2.
  task automatic run_a(input logic mode, input int n, input logic [31:0] bits);
    a_rdy  = 1'b1;
    a_mode = mode;
    for (int j = 0; j <= n + 1; j++) begin
      a_ro[0] = (j < n) ? bits[31-j] : 1'b0;
      a_en    = (j >= 2);
      if (j == n + 1) check("a_valid_before_last_bit", 32'(a_vld), 32'd0);
      step();
    end
    a_en = 1'b0;
    check("a_valid_after_last_bit", 32'(a_vld), 32'd1);
    repeat (4) step();
    check("a_all_words_seen", 32'(qa.size()), 32'd0);
  endtask

  initial begin
    logic [47:0] s4;
    logic [31:0] s6;

    vecs[0] = '{mode: 1'b0, n: 8,  bits: 32'hB200_0000, nw: 1, w0: 8'hB2, w1: 8'h00};
    vecs[1] = '{mode: 1'b1, n: 20, bits: 32'h6CA5_9000, nw: 1, w0: 8'h72, w1: 8'h00};
    vecs[2] = '{mode: 1'b0, n: 16, bits: 32'hA50F_0000, nw: 2, w0: 8'hA5, w1: 8'h0F};
    vecs[3] = '{mode: 1'b1, n: 16, bits: 32'h9699_0000, nw: 1, w0: 8'h9A, w1: 8'h00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_data_out", 32'(a_out), 32'd0);
    check("rst_a_valid", 32'(a_vld), 32'd0);
    check("rst_a_health", 32'(a_hf), 32'd0);
    check("rst_b_valid", 32'(b_vld), 32'd0);
    check("rst_fifo_empty", 32'(f_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: raw and debiased packing
    foreach (vecs[i]) begin
      qa.push_back(vecs[i].w0);
      if (vecs[i].nw > 1) qa.push_back(vecs[i].w1);
      run_a(vecs[i].mode, vecs[i].n, vecs[i].bits);
    end

    // Four-channel XOR: ch0 alone -> 1, ch0^ch1 -> 0
    qb.push_back(8'hFF);
    qb.push_back(8'h00);
    b_rdy = 1'b1;
    for (int j = 0; j <= 17; j++) begin
      b_ro = (j < 8) ? 4'b0001 : 4'b0011;
      b_en = (j >= 2);
      step();
    end
    b_en = 1'b0;
    repeat (4) step();
    check("b_all_words_seen", 32'(qb.size()), 32'd0);
    check("b_health_clear", 32'(b_hf), 32'd0);

    // Back-pressure: four words fill the FIFO, sampling freezes, then resumes gap-free
    s4 = 48'hB25A_C369_9D4E;
    qa.push_back(8'hB2); qa.push_back(8'h5A); qa.push_back(8'hC3);
    qa.push_back(8'h69); qa.push_back(8'h9D); qa.push_back(8'h4E);
    a_mode = 1'b0;
    for (int j = 0; j <= 61; j++) begin
      int k;
      if (j < 32) k = j;
      else if (j <= 43) k = 32;
      else if (j <= 58) k = j - 11;
      else k = 47;
      a_ro[0] = s4[47-k];
      a_en    = (j >= 2) && (j <= 60);
      a_rdy   = (j >= 45);
      if (j == 44) begin
        check("stall_fifo_count", 32'(dut_a.u_fifo.o_count), 32'd4);
        check("stall_valid", 32'(a_vld), 32'd1);
        check("stall_head_stable", 32'(a_out), 32'hB2);
        check("stall_bit_count", 32'(dut_a.r_bcnt), 32'd0);
      end
      step();
    end
    a_en  = 1'b0;
    a_rdy = 1'b1;
    repeat (8) step();
    check("stall_all_words_seen", 32'(qa.size()), 32'd0);

    // Repetition-count trip on a stuck input, then recovery via enable
    a_mode = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      a_ro[0] = 1'b1;
      a_en    = (j >= 2);
      if (j == 9)  check("rct_not_yet", 32'(a_hf), 32'd0);
      if (j == 10) check("rct_trip_8th", 32'(a_hf), 32'd1);
      step();
    end
    check("rct_no_word", 32'(a_vld), 32'd0);
    check("rct_sticky", 32'(a_hf), 32'd1);
    a_en = 1'b0;
    step();
    check("rct_cleared_by_enable", 32'(a_hf), 32'd0);
    qa.push_back(8'hB2);
    run_a(1'b0, 8, 32'hB200_0000);

    // Reset with a word queued and five bits of the next one in flight
    s6 = 32'h6BA0_0000;
    a_rdy  = 1'b0;
    a_mode = 1'b0;
    for (int j = 0; j <= 14; j++) begin
      a_ro[0] = (j < 13) ? s6[31-j] : 1'b0;
      a_en    = (j >= 2);
      step();
    end
    check("pre_rst_valid", 32'(a_vld), 32'd1);
    check("pre_rst_head", 32'(a_out), 32'h6B);
    check("pre_rst_bits", 32'(dut_a.r_bcnt), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data_out", 32'(a_out), 32'd0);
    check("async_rst_valid", 32'(a_vld), 32'd0);
    check("async_rst_health", 32'(a_hf), 32'd0);
    a_en = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    qa.push_back(8'h3C);
    run_a(1'b0, 8, 32'h3C00_0000);

    // Standalone FIFO: fill, rejected push, push+pop while full, drain order
    for (int i = 0; i < 4; i++) begin
      f_push = 1'b1;
      f_din  = 8'(8'h11 * (i + 1));
      step();
    end
    check("fifo_full", 32'(f_full), 32'd1);
    check("fifo_count_full", 32'(f_cnt), 32'd4);
    f_din = 8'h66;
    step();
    check("fifo_push_when_full_ignored", 32'(f_cnt), 32'd4);
    check("fifo_head_before_pp", 32'(f_head), 32'h11);
    f_din = 8'h55;
    f_pop = 1'b1;
    step();
    f_push = 1'b0;
    f_pop  = 1'b0;
    check("fifo_push_pop_full_count", 32'(f_cnt), 32'd4);
    check("fifo_push_pop_full_flag", 32'(f_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_w;
      exp_w = (i < 3) ? 8'(8'h22 + 8'h11 * i) : 8'h55;
      check("fifo_drain_order", 32'(f_head), 32'(exp_w));
      f_pop = 1'b1;
      step();
    end
    f_pop = 1'b0;
    check("fifo_empty_after_drain", 32'(f_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
